mem_arbiter: RTL and testbench

Shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch port and data port. It sequences each access through issue, wait and done phases. It raises `stall` to freeze the pipeline while any requester is waiting. Data accesses take priority, with an alternation rule so that neither port can starve. It sits between the core's `iadr`/`imemrd` and `dadr`/`dmemrd`/`dmemread`/`dmemwrite`/`dmemwd` ports and the physical memory.

---
 rtl/mem_arbiter_pkg.sv | 33 +++
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter_lat_counter.sv | 34 +++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_MEM_LATENCY = 2;

  // Data first, but alternate when both ports keep requesting.
  function automatic owner_e pick_owner(input logic i_req, input logic d_req, input owner_e last);
    owner_e win;
    if (i_req && d_req) begin
      win = (last == OWN_D) ? OWN_I : OWN_D;
    end else if (d_req) begin
      win = OWN_D;
    end else begin
      win = OWN_I;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request/response and memory-side bus signals of the memory arbiter.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_adr;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_ready;

  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_adr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_ready;

  logic [ADDR_WIDTH-1:0] m_adr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic                  m_read;
  logic                  m_write;
  logic [DATA_WIDTH-1:0] m_rdata;

  logic                  stall;

  modport slave (
    input  i_req, i_adr, d_read, d_write, d_adr, d_wdata, m_rdata,
    output i_rdata, i_ready, d_rdata, d_ready, m_adr, m_wdata, m_read, m_write, stall
  );

  modport master (
    output i_req, i_adr, d_read, d_write, d_adr, d_wdata, m_rdata,
    input  i_rdata, i_ready, d_rdata, d_ready, m_adr, m_wdata, m_read, m_write, stall
  );

endinterface

// File: rtl/mem_arbiter_lat_counter.sv
// Down-counter timing the memory latency; flags zero, saturates at zero.
module lat_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch and data ports.
// state    | meaning
// ST_IDLE  | pick owner, latch address/data/direction
// ST_ISSUE | memory strobe high, latency counter loaded
// ST_WAIT  | count down, capture read data at zero
// ST_DONE  | owner's ready pulse
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                last_q, last_d;
  logic                  is_write_q, is_write_d;
  logic [ADDR_WIDTH-1:0] m_adr_q, m_adr_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic                  m_read_q, m_read_d;
  logic                  m_write_q, m_write_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  i_ready_q, i_ready_d;
  logic                  d_ready_q, d_ready_d;

  logic   d_req;
  logic   cnt_load, cnt_dec, cnt_zero;
  owner_e grant;

  assign d_req = bus.d_read | bus.d_write;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    is_write_d = is_write_q;
    m_adr_d    = m_adr_q;
    m_wdata_d  = m_wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    m_read_d   = 1'b0;
    m_write_d  = 1'b0;
    i_ready_d  = 1'b0;
    d_ready_d  = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    grant      = pick_owner(bus.i_req, d_req, last_q);

    case (state_q)
      ST_IDLE: begin
        if (bus.i_req || d_req) begin
          owner_d = grant;
          last_d  = grant;
          if (grant == OWN_D) begin
            m_adr_d    = bus.d_adr;
            m_wdata_d  = bus.d_wdata;
            is_write_d = bus.d_write;
          end else begin
            m_adr_d    = bus.i_adr;
            m_wdata_d  = '0;
            is_write_d = 1'b0;
          end
          // Strobes are registered so they appear exactly in the ISSUE cycle.
          m_read_d  = ~is_write_d;
          m_write_d = is_write_d;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          if (owner_q == OWN_D) begin
            d_ready_d = 1'b1;
            if (!is_write_q) begin
              d_rdata_d = bus.m_rdata;
            end
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = bus.m_rdata;
          end
          state_d = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_I;
      last_q     <= OWN_I;
      is_write_q <= 1'b0;
      m_adr_q    <= '0;
      m_wdata_q  <= '0;
      m_read_q   <= 1'b0;
      m_write_q  <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_ready_q  <= 1'b0;
      d_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      is_write_q <= is_write_d;
      m_adr_q    <= m_adr_d;
      m_wdata_q  <= m_wdata_d;
      m_read_q   <= m_read_d;
      m_write_q  <= m_write_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_ready_q  <= i_ready_d;
      d_ready_q  <= d_ready_d;
    end
  end

  lat_counter #(
    .WIDTH(CNT_W)
  ) u_lat_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .dec     (cnt_dec),
    .load_val(CNT_LOAD),
    .zero    (cnt_zero)
  );

  assign bus.m_adr   = m_adr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_read  = m_read_q;
  assign bus.m_write = m_write_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_ready = i_ready_q;
  assign bus.d_ready = d_ready_q;
  assign bus.stall   = (bus.i_req & ~i_ready_q) | (d_req & ~d_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level schedule model checked every cycle,
// plus literal expectations from hand-worked timelines (latency 2 and latency 1 builds).
module tb_mem_arbiter;

  localparam int LAT  = 2;
  localparam int MAXC = 1024;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_err;

  mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1)) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Memory image seen by the environment (updated by DUT writes) and by the model.
  logic [31:0] env_mem   [256];
  logic [31:0] model_mem [256];
  bit          due_v     [MAXC];
  logic [31:0] due_d     [MAXC];

  initial begin
    for (int k = 0; k < 256; k++) begin
      env_mem[k]   = 32'h1000_0000 | (32'(k) << 2);
      model_mem[k] = 32'h1000_0000 | (32'(k) << 2);
    end
    env_mem[16]   = 32'h8C01_0004;
    model_mem[16] = 32'h8C01_0004;
  end

  initial begin : env_obs
    forever begin
      @(negedge clk);
      if (bus.m_read === 1'b1 && cyc + LAT < MAXC) begin
        due_v[cyc+LAT] = 1'b1;
        due_d[cyc+LAT] = env_mem[bus.m_adr[9:2]];
      end
      if (bus.m_write === 1'b1) begin
        env_mem[bus.m_adr[9:2]] = bus.m_wdata;
      end
    end
  end

  initial begin : env_drv
    bus.m_rdata = 32'hDEAD_0000;
    forever begin
      @(posedge clk);
      #1;
      bus.m_rdata = (cyc < MAXC && due_v[cyc]) ? due_d[cyc] : (32'hDEAD_0000 | 32'(cyc));
    end
  end

  // Expected-event schedule indexed by absolute cycle.
  bit          ev_mrd  [MAXC];
  bit          ev_mwr  [MAXC];
  bit          ev_ird  [MAXC];
  bit          ev_drd  [MAXC];
  bit          win     [MAXC];
  bit          win_wr  [MAXC];
  logic [31:0] win_adr [MAXC];
  logic [31:0] win_wd  [MAXC];
  bit          upd_i_v [MAXC];
  bit          upd_d_v [MAXC];
  logic [31:0] upd_i_d [MAXC];
  logic [31:0] upd_d_d [MAXC];

  logic [31:0] exp_i_rdata;
  logic [31:0] exp_d_rdata;
  int          busy_until;
  bit          last_d;
  bit          rst_prev;

  initial begin : model_p
    int          c;
    bit          iq, dq, own_d, wr;
    logic [31:0] adr, wd;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    busy_until  = 0;
    last_d      = 1'b0;
    rst_prev    = 1'b0;
    forever begin
      @(negedge clk);
      c = cyc;
      if (c < MAXC - 16) begin
        if (upd_i_v[c]) exp_i_rdata = upd_i_d[c];
        if (upd_d_v[c]) exp_d_rdata = upd_d_d[c];
        iq = bus.i_req;
        dq = bus.d_read | bus.d_write;
        if (c >= 1) begin
          chk("m_read",  32'(bus.m_read),  32'(ev_mrd[c]));
          chk("m_write", 32'(bus.m_write), 32'(ev_mwr[c]));
          chk("i_ready", 32'(bus.i_ready), 32'(ev_ird[c]));
          chk("d_ready", 32'(bus.d_ready), 32'(ev_drd[c]));
          chk("stall",   32'(bus.stall),   32'((iq & ~ev_ird[c]) | (dq & ~ev_drd[c])));
          chk("i_rdata", bus.i_rdata, exp_i_rdata);
          chk("d_rdata", bus.d_rdata, exp_d_rdata);
          if (win[c]) chk("m_adr", bus.m_adr, win_adr[c]);
          if (win[c] && win_wr[c]) chk("m_wdata", bus.m_wdata, win_wd[c]);
          if (rst_prev) begin
            chk("m_adr_rst",   bus.m_adr,   32'h0);
            chk("m_wdata_rst", bus.m_wdata, 32'h0);
          end
        end
        rst_prev = reset;
        if (reset) begin
          for (int k = c + 1; k < c + 16; k++) begin
            ev_mrd[k] = 0; ev_mwr[k] = 0; ev_ird[k] = 0; ev_drd[k] = 0;
            win[k] = 0; win_wr[k] = 0; upd_i_v[k] = 0; upd_d_v[k] = 0;
          end
          busy_until  = c + 1;
          last_d      = 1'b0;
          exp_i_rdata = '0;
          exp_d_rdata = '0;
        end else if (c >= busy_until && (iq || dq)) begin
          own_d = dq && (!iq || !last_d);
          wr    = own_d && bus.d_write;
          adr   = own_d ? bus.d_adr : bus.i_adr;
          wd    = bus.d_wdata;
          ev_mrd[c+1] = !wr;
          ev_mwr[c+1] = wr;
          for (int k = c + 1; k <= c + 1 + LAT; k++) begin
            win[k] = 1; win_wr[k] = wr; win_adr[k] = adr; win_wd[k] = wd;
          end
          if (own_d) begin
            ev_drd[c+2+LAT] = 1;
            if (!wr) begin
              upd_d_v[c+2+LAT] = 1;
              upd_d_d[c+2+LAT] = model_mem[adr[9:2]];
            end else begin
              model_mem[adr[9:2]] = wd;
            end
          end else begin
            ev_ird[c+2+LAT]  = 1;
            upd_i_v[c+2+LAT] = 1;
            upd_i_d[c+2+LAT] = model_mem[adr[9:2]];
          end
          last_d     = own_d;
          busy_until = c + 3 + LAT;
        end
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : stim
    int t0;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.i_req = 0; bus.i_adr = 0; bus.d_read = 0; bus.d_write = 0;
    bus.d_adr = 0; bus.d_wdata = 0;
    bus1.i_req = 0; bus1.i_adr = 0; bus1.d_read = 0; bus1.d_write = 0;
    bus1.d_adr = 0; bus1.d_wdata = 0; bus1.m_rdata = 32'hBAD0_0000;
    goto(3);
    reset = 1'b0;

    // Fetch only.
    t0 = 5;
    goto(t0); bus.i_req = 1; bus.i_adr = 32'h40;
    @(negedge clk); chk("t1_stall_c0", 32'(bus.stall), 32'd1);
    goto(t0 + 1); @(negedge clk);
    chk("t1_m_read", 32'(bus.m_read), 32'd1);
    chk("t1_m_adr", bus.m_adr, 32'h40);
    goto(t0 + 3); @(negedge clk); chk("t1_stall_c3", 32'(bus.stall), 32'd1);
    goto(t0 + 4); @(negedge clk);
    chk("t1_i_ready", 32'(bus.i_ready), 32'd1);
    chk("t1_i_rdata", bus.i_rdata, 32'h8C01_0004);
    chk("t1_stall_c4", 32'(bus.stall), 32'd0);
    goto(t0 + 5); bus.i_req = 0;

    // Simultaneous fetch and data read: data first.
    t0 = 12;
    goto(t0); bus.i_req = 1; bus.i_adr = 32'h44; bus.d_read = 1; bus.d_adr = 32'h100;
    goto(t0 + 1); @(negedge clk); chk("t2_m_adr_d", bus.m_adr, 32'h100);
    goto(t0 + 4); @(negedge clk);
    chk("t2_d_ready", 32'(bus.d_ready), 32'd1);
    chk("t2_d_rdata", bus.d_rdata, 32'h1000_0100);
    chk("t2_stall_c4", 32'(bus.stall), 32'd1);
    goto(t0 + 5); bus.d_read = 0;
    goto(t0 + 6); @(negedge clk);
    chk("t2_m_read_i", 32'(bus.m_read), 32'd1);
    chk("t2_m_adr_i", bus.m_adr, 32'h44);
    goto(t0 + 8); @(negedge clk); chk("t2_stall_c8", 32'(bus.stall), 32'd1);
    goto(t0 + 9); @(negedge clk);
    chk("t2_i_ready", 32'(bus.i_ready), 32'd1);
    chk("t2_stall_c9", 32'(bus.stall), 32'd0);
    goto(t0 + 10); bus.i_req = 0;

    // Back-to-back writes against a continuous fetch: D, I, D, I.
    t0 = 24;
    goto(t0); bus.i_req = 1; bus.i_adr = 32'h48;
    bus.d_write = 1; bus.d_adr = 32'h200; bus.d_wdata = 32'hCAFE_0001;
    goto(t0 + 1); @(negedge clk);
    chk("t3_m_write1", 32'(bus.m_write), 32'd1);
    chk("t3_m_adr1", bus.m_adr, 32'h200);
    chk("t3_m_wdata1", bus.m_wdata, 32'hCAFE_0001);
    goto(t0 + 2); @(negedge clk); chk("t3_m_write_off", 32'(bus.m_write), 32'd0);
    goto(t0 + 5); bus.d_adr = 32'h204; bus.d_wdata = 32'hCAFE_0002;
    goto(t0 + 6); @(negedge clk);
    chk("t3_m_read_i", 32'(bus.m_read), 32'd1);
    chk("t3_m_adr_i", bus.m_adr, 32'h48);
    goto(t0 + 10); bus.i_adr = 32'h4C;
    goto(t0 + 11); @(negedge clk);
    chk("t3_m_write2", 32'(bus.m_write), 32'd1);
    chk("t3_m_adr2", bus.m_adr, 32'h204);
    chk("t3_m_wdata2", bus.m_wdata, 32'hCAFE_0002);
    goto(t0 + 14); @(negedge clk);
    chk("t3_d_ready2", 32'(bus.d_ready), 32'd1);
    chk("t3_d_rdata_kept", bus.d_rdata, 32'h1000_0100);
    goto(t0 + 15); bus.d_write = 0;
    goto(t0 + 19); @(negedge clk);
    chk("t3_i_ready2", 32'(bus.i_ready), 32'd1);
    chk("t3_i_rdata2", bus.i_rdata, 32'h1000_004C);
    goto(t0 + 20); bus.i_req = 0;

    // Reset in the middle of a read.
    t0 = 46;
    goto(t0); bus.d_read = 1; bus.d_adr = 32'h104;
    goto(t0 + 2); reset = 1; bus.d_read = 0;
    goto(t0 + 3); reset = 0;
    @(negedge clk);
    chk("t4_m_read", 32'(bus.m_read), 32'd0);
    chk("t4_m_write", 32'(bus.m_write), 32'd0);
    chk("t4_i_ready", 32'(bus.i_ready), 32'd0);
    chk("t4_m_adr", bus.m_adr, 32'h0);
    chk("t4_m_wdata", bus.m_wdata, 32'h0);
    chk("t4_i_rdata", bus.i_rdata, 32'h0);
    chk("t4_d_rdata", bus.d_rdata, 32'h0);
    for (int k = 3; k < 10; k++) begin
      goto(t0 + k); @(negedge clk);
      chk("t4_no_d_ready", 32'(bus.d_ready), 32'd0);
    end

    // Fresh arbitration after reset, then a fetch dropped during WAIT.
    t0 = 58;
    goto(t0); bus.i_req = 1; bus.i_adr = 32'h50; bus.d_read = 1; bus.d_adr = 32'h204;
    goto(t0 + 1); @(negedge clk); chk("t5_m_adr_d", bus.m_adr, 32'h204);
    goto(t0 + 4); @(negedge clk);
    chk("t5_d_ready", 32'(bus.d_ready), 32'd1);
    chk("t5_d_rdata", bus.d_rdata, 32'hCAFE_0002);
    goto(t0 + 5); bus.d_read = 0;
    goto(t0 + 7); bus.i_req = 0;
    goto(t0 + 8); bus.d_read = 1; bus.d_adr = 32'h40;
    goto(t0 + 9); @(negedge clk);
    chk("t5_i_ready", 32'(bus.i_ready), 32'd1);
    chk("t5_i_rdata", bus.i_rdata, 32'h1000_0050);
    chk("t5_stall_d", 32'(bus.stall), 32'd1);
    goto(t0 + 10); @(negedge clk); chk("t5_idle_no_strobe", 32'(bus.m_read), 32'd0);
    goto(t0 + 11); @(negedge clk);
    chk("t5_m_read_next", 32'(bus.m_read), 32'd1);
    chk("t5_m_adr_next", bus.m_adr, 32'h40);
    goto(t0 + 14); @(negedge clk);
    chk("t5_d_rdata_next", bus.d_rdata, 32'h8C01_0004);
    goto(t0 + 15); bus.d_read = 0;

    // Latency-1 build: capture from the cycle right after ISSUE.
    t0 = 76;
    goto(t0); bus1.i_req = 1; bus1.i_adr = 32'h80;
    goto(t0 + 1); @(negedge clk);
    chk("t6_m_read", 32'(bus1.m_read), 32'd1);
    chk("t6_m_adr", bus1.m_adr, 32'h80);
    goto(t0 + 2); bus1.m_rdata = 32'h5A5A_0080;
    @(negedge clk);
    chk("t6_i_ready_early", 32'(bus1.i_ready), 32'd0);
    chk("t6_stall_wait", 32'(bus1.stall), 32'd1);
    goto(t0 + 3); bus1.m_rdata = 32'hBAD0_0003;
    @(negedge clk);
    chk("t6_i_ready", 32'(bus1.i_ready), 32'd1);
    chk("t6_i_rdata", bus1.i_rdata, 32'h5A5A_0080);
    chk("t6_stall_done", 32'(bus1.stall), 32'd0);
    goto(t0 + 4); bus1.i_req = 0;
    @(negedge clk);
    chk("t6_i_ready_once", 32'(bus1.i_ready), 32'd0);
    chk("t6_m_read_off", 32'(bus1.m_read), 32'd0);

    goto(t0 + 8);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
